rgs_bus_arb: RTL and testbench

//  Round-robin arbiter and sequencer sharing the single rgs host register port (wr/rd/addr/data)

---
 rtl/rgs_bus_arb.sv | 158 +++++++++++++++
 tb/tb_rgs_bus_arb.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rgs_bus_arb.sv
// rgs_bus_arb: round-robin arbiter and sequencer sharing the single rgs host
// register port between two masters (M0 = host CPU, M1 = PTP servo engine).
// One transaction at a time. Each transaction issues a single-cycle rgs strobe,
// waits RD_LAT cycles for reads, and returns a one-cycle ack to the owning
// master, with read data for reads.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   mX_req/wr/addr/wdata         master X command (held stable while req=1)
//   mX_ack                       one-cycle completion pulse
//   mX_rdata                     read data, valid with mX_ack; held until the
//                                next read ack to the same master
//   wr_out/rd_out/addr_out/data_out  rgs strobes and command (all registered)
//   data_in                      rgs read data
//   busy                         transaction in progress (state != IDLE)
module rgs_bus_arb #(
  parameter int AW     = 6,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_wr,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_wr,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          wr_out,
  output logic          rd_out,
  output logic [AW-1:0] addr_out,
  output logic [DW-1:0] data_out,
  input  logic [DW-1:0] data_in,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RWAIT, ACK} state_t;

  // Counter is loaded with RD_LAT-1 so the last RWAIT cycle is the one
  // in which rgs data_out is valid.
  localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

  state_t        state, state_nxt;
  logic          owner, owner_nxt;        // 0 = M0, 1 = M1
  logic          cmd_wr, cmd_wr_nxt;
  logic          last_gnt, last_gnt_nxt;
  logic [2:0]    cnt, cnt_nxt;
  logic          gnt;

  logic          wr_nxt, rd_nxt, busy_nxt;
  logic          m0_ack_nxt, m1_ack_nxt;
  logic [AW-1:0] addr_nxt;
  logic [DW-1:0] data_nxt, m0_rdata_nxt, m1_rdata_nxt;

  // Lone requester wins; on a tie, the master not granted last time wins.
  assign gnt = (m0_req && m1_req) ? ~last_gnt : m1_req;

  // Outputs are registered, so this block computes the values they take in
  // the cycle of state_nxt (e.g. the ISSUE strobe is set on the IDLE edge).
  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    cmd_wr_nxt   = cmd_wr;
    last_gnt_nxt = last_gnt;
    cnt_nxt      = cnt;
    wr_nxt       = 1'b0;
    rd_nxt       = 1'b0;
    m0_ack_nxt   = 1'b0;
    m1_ack_nxt   = 1'b0;
    addr_nxt     = addr_out;
    data_nxt     = data_out;
    m0_rdata_nxt = m0_rdata;
    m1_rdata_nxt = m1_rdata;
    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          owner_nxt    = gnt;
          last_gnt_nxt = gnt;
          cmd_wr_nxt   = gnt ? m1_wr    : m0_wr;
          addr_nxt     = gnt ? m1_addr  : m0_addr;
          data_nxt     = gnt ? m1_wdata : m0_wdata;
          wr_nxt       = cmd_wr_nxt;
          rd_nxt       = ~cmd_wr_nxt;
          // Writes complete in the strobe cycle itself.
          m0_ack_nxt   = cmd_wr_nxt & ~gnt;
          m1_ack_nxt   = cmd_wr_nxt & gnt;
          state_nxt    = ISSUE;
        end
      end
      ISSUE: begin
        if (cmd_wr) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = RWAIT;
          cnt_nxt   = CNT_INIT;
        end
      end
      RWAIT: begin
        if (cnt == 3'd0) begin
          state_nxt = ACK;
          if (owner) begin
            m1_rdata_nxt = data_in;
            m1_ack_nxt   = 1'b1;
          end else begin
            m0_rdata_nxt = data_in;
            m0_ack_nxt   = 1'b1;
          end
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= 1'b0;
      cmd_wr   <= 1'b0;
      last_gnt <= 1'b1;
      cnt      <= 3'd0;
      wr_out   <= 1'b0;
      rd_out   <= 1'b0;
      addr_out <= '0;
      data_out <= '0;
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      cmd_wr   <= cmd_wr_nxt;
      last_gnt <= last_gnt_nxt;
      cnt      <= cnt_nxt;
      wr_out   <= wr_nxt;
      rd_out   <= rd_nxt;
      addr_out <= addr_nxt;
      data_out <= data_nxt;
      m0_ack   <= m0_ack_nxt;
      m1_ack   <= m1_ack_nxt;
      m0_rdata <= m0_rdata_nxt;
      m1_rdata <= m1_rdata_nxt;
      busy     <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_rgs_bus_arb.sv
// Bench for rgs_bus_arb: two instances (RD_LAT=1 and RD_LAT=3) share the same
// master stimulus. A transaction-position model predicts every output of both
// instances each cycle; directed steps add literal expectations.
module tb_rgs_bus_arb;
  localparam int AW = 6;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_wr, m1_req, m1_wr;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, data_in;

  logic [1:0]          m0_ack, m1_ack, wr_o, rd_o, busy_o;
  logic [1:0][AW-1:0]  addr_o;
  logic [1:0][DW-1:0]  dout, m0_rd, m1_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rgs_bus_arb #(.AW(AW), .DW(DW), .RD_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack[0]), .m0_rdata(m0_rd[0]),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack[0]), .m1_rdata(m1_rd[0]),
    .wr_out(wr_o[0]), .rd_out(rd_o[0]), .addr_out(addr_o[0]), .data_out(dout[0]),
    .data_in(data_in), .busy(busy_o[0]));

  rgs_bus_arb #(.AW(AW), .DW(DW), .RD_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack[1]), .m0_rdata(m0_rd[1]),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack[1]), .m1_rdata(m1_rd[1]),
    .wr_out(wr_o[1]), .rd_out(rd_o[1]), .addr_out(addr_o[1]), .data_out(dout[1]),
    .data_in(data_in), .busy(busy_o[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Model: a transaction occupies positions 1..len (1 = strobe cycle).
  // Write len=1 (ack with strobe); read len=lat+2 (strobe, lat waits, ack).
  // pos=0 means idle; a new capture only happens from idle.
  int          lat [2] = '{1, 3};
  int          pos [2];
  logic        own [2], cwr [2], lastg [2];
  logic [AW-1:0] caddr [2];
  logic [DW-1:0] cwd [2], r0 [2], r1 [2];
  bit          mvalid = 1'b0;

  function automatic int tlen(input int d);
    return cwr[d] ? 1 : lat[d] + 2;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        pos[d] = 0; own[d] = 1'b0; cwr[d] = 1'b0; lastg[d] = 1'b1;
        caddr[d] = '0; cwd[d] = '0; r0[d] = '0; r1[d] = '0;
      end else if (pos[d] == 0) begin
        if (m0_req || m1_req) begin
          own[d]   = (m0_req && m1_req) ? ~lastg[d] : m1_req;
          lastg[d] = own[d];
          cwr[d]   = own[d] ? m1_wr    : m0_wr;
          caddr[d] = own[d] ? m1_addr  : m0_addr;
          cwd[d]   = own[d] ? m1_wdata : m0_wdata;
          pos[d]   = 1;
        end
      end else if (pos[d] == tlen(d)) begin
        pos[d] = 0;
      end else begin
        pos[d] = pos[d] + 1;
        if (pos[d] == tlen(d)) begin
          if (own[d]) r1[d] = data_in; else r0[d] = data_in;
        end
      end
    end
    if (rst) mvalid = 1'b1;
  end

  always @(negedge clk) begin
    if (mvalid) begin
      for (int d = 0; d < 2; d++) begin
        logic ea;
        ea = (pos[d] != 0) && (pos[d] == tlen(d));
        chk($sformatf("d%0d wr_out", d),   wr_o[d],   pos[d] == 1 && cwr[d]);
        chk($sformatf("d%0d rd_out", d),   rd_o[d],   pos[d] == 1 && !cwr[d]);
        chk($sformatf("d%0d m0_ack", d),   m0_ack[d], ea && !own[d]);
        chk($sformatf("d%0d m1_ack", d),   m1_ack[d], ea && own[d]);
        chk($sformatf("d%0d busy", d),     busy_o[d], pos[d] != 0);
        chk($sformatf("d%0d addr_out", d), addr_o[d], caddr[d]);
        chk($sformatf("d%0d data_out", d), dout[d],   cwd[d]);
        chk($sformatf("d%0d m0_rdata", d), m0_rd[d],  r0[d]);
        chk($sformatf("d%0d m1_rdata", d), m1_rd[d],  r1[d]);
      end
    end
  end

  task automatic nc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [3:0] seq;
    int na, n0, n3;
    rst = 1'b1; m0_req = 0; m1_req = 0; m0_wr = 0; m1_wr = 0;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0; data_in = '0;
    nc(2);
    chk("reset busy", busy_o, 2'b00);
    chk("reset wr", wr_o, 2'b00);
    chk("reset ack", {m0_ack, m1_ack}, 4'h0);
    chk("reset addr", addr_o[0], 0);
    chk("reset rdata", m0_rd[0], 0);
    rst = 1'b0;

    // 1: M0 write, ack in strobe cycle
    m0_req = 1; m0_wr = 1; m0_addr = 6'h04; m0_wdata = 32'hDEADBEEF;
    nc(1);
    chk("t1 wr_out", wr_o[0], 1);
    chk("t1 addr", addr_o[0], 32'h04);
    chk("t1 data", dout[0], 32'hDEADBEEF);
    chk("t1 m0_ack", m0_ack[0], 1);
    chk("t1 m1_ack", m1_ack[0], 0);
    m0_req = 0;
    nc(1);
    chk("t1 wr_out low", wr_o[0], 0);
    chk("t1 ack low", m0_ack[0], 0);
    chk("t1 idle", busy_o[0], 0);

    // 2: M1 read, ack at N+2 (lat 1) and N+4 (lat 3)
    m1_req = 1; m1_wr = 0; m1_addr = 6'h10; data_in = 32'h12345678;
    nc(1);
    chk("t2 rd_out", rd_o, 2'b11);
    chk("t2 addr", addr_o[0], 32'h10);
    m1_req = 0;
    nc(1);
    chk("t2 early ack", m1_ack[0], 0);
    nc(1);
    chk("t2 ack lat1", m1_ack[0], 1);
    chk("t2 rdata lat1", m1_rd[0], 32'h12345678);
    chk("t2 no ack lat3", m1_ack[1], 0);
    nc(2);
    chk("t2 ack lat3", m1_ack[1], 1);
    chk("t2 rdata lat3", m1_rd[1], 32'h12345678);
    nc(2);

    // 3: both request from reset, alternating grants
    rst = 1; nc(1); rst = 0;
    m0_req = 1; m0_wr = 1; m0_addr = 6'h01; m0_wdata = 32'h100;
    m1_req = 1; m1_wr = 1; m1_addr = 6'h02; m1_wdata = 32'h200;
    seq = '0; na = 0;
    for (int i = 0; i < 8; i++) begin
      nc(1);
      if (m0_ack[0] || m1_ack[0]) begin
        if (na < 4) seq[na] = m1_ack[0];
        na++;
      end
    end
    m0_req = 0; m1_req = 0;
    chk("t3 ack count", na, 4);
    chk("t3 grant order", seq, 4'b1010);
    nc(2);

    // 4: M0 held, M1 served at the next idle after M0's read
    m0_req = 1; m0_wr = 0; m0_addr = 6'h08; data_in = 32'hA5A50F0F;
    nc(2);
    m1_req = 1; m1_wr = 1; m1_addr = 6'h0C; m1_wdata = 32'hCAFE0001;
    nc(1);
    chk("t4 m0 ack", m0_ack[0], 1);
    chk("t4 m0 rdata", m0_rd[0], 32'hA5A50F0F);
    nc(1);
    chk("t4 idle gap", busy_o[0], 0);
    nc(1);
    chk("t4 m1 granted", m1_ack[0], 1);
    chk("t4 m1 addr", addr_o[0], 32'h0C);
    m0_req = 0; m1_req = 0;
    nc(6);

    // 5: reset during read wait
    m0_req = 1; m0_wr = 0; m0_addr = 6'h14; data_in = 32'h55;
    nc(2);
    rst = 1; m0_req = 0;
    nc(1);
    chk("t5 busy", busy_o, 2'b00);
    chk("t5 acks", {m0_ack, m1_ack}, 4'h0);
    chk("t5 addr", {addr_o[1], addr_o[0]}, 0);
    chk("t5 rdata", m0_rd[0], 0);
    rst = 0;
    m0_req = 1; m0_wr = 1; m1_req = 1; m1_wr = 1;
    nc(1);
    chk("t5 m0 wins", m0_ack, 2'b11);
    chk("t5 m1 waits", m1_ack, 2'b00);
    m0_req = 0; m1_req = 0;
    nc(2);

    // 6: M0 drops req right after capture
    m0_req = 1; m0_wr = 0; m0_addr = 6'h18; data_in = 32'h600D;
    nc(1);
    m0_req = 0;
    n0 = 0; n3 = 0;
    for (int i = 0; i < 6; i++) begin
      nc(1);
      n0 += int'(m0_ack[0]);
      n3 += int'(m0_ack[1]);
    end
    chk("t6 one ack lat1", n0, 1);
    chk("t6 one ack lat3", n3, 1);
    chk("t6 idle", busy_o, 2'b00);
    chk("t6 rdata", m0_rd[1], 32'h600D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
